// File: rtl/arbitro_tx_serial.sv
// arbitro_tx_serial: arbitrates two ASCII request channels (A/B) onto a single
// 7N2 serial transmitter. Alternating priority on simultaneous requests, a
// per-character timeout while waiting for tx_pronto, and one-cycle ack/erro
// completion pulses. All outputs are registered.
module arbitro_tx_serial #(
  parameter int unsigned TIMEOUT_CICLOS = 60000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_a,
  input  logic [6:0] dado_a,
  input  logic       req_b,
  input  logic [6:0] dado_b,
  input  logic       tx_pronto,
  output logic       tx_partida,
  output logic [6:0] tx_dados,
  output logic       ack_a,
  output logic       ack_b,
  output logic       erro,
  output logic       ocupado,
  output logic [3:0] db_estado,
  output logic       db_vez
);

  localparam int unsigned W_CONT = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [W_CONT-1:0] C_LIMITE = W_CONT'(TIMEOUT_CICLOS - 1);

  typedef enum logic [3:0] {
    INICIAL = 4'h0,
    OCIOSO  = 4'h1,
    CAPTURA = 4'h2,
    PARTIDA = 4'h3,
    ESPERA  = 4'h4,
    FIM     = 4'h5,
    ERRO    = 4'hF
  } t_estado;

  t_estado           r_estado;
  logic              r_vez;       // 0 = A has priority, 1 = B has priority
  logic              r_canal;     // channel currently being served (0 = A)
  logic [W_CONT-1:0] r_contador;
  logic              r_tx_partida;
  logic [6:0]        r_tx_dados;
  logic              r_ack_a;
  logic              r_ack_b;
  logic              r_erro;      // abort flag, visible only in FIM
  logic              r_ocupado;

  // Wait-for-tx_pronto decisions; tx_pronto takes precedence over the timeout.
  logic w_fim_ok;
  logic w_fim_timeout;
  assign w_fim_ok      = tx_pronto;
  assign w_fim_timeout = !tx_pronto && (r_contador == C_LIMITE);

  // Arbitration FSM; outputs are set on the transition into the state that
  // shows them, so each output is valid for exactly the cycle of that state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado     <= INICIAL;
      r_vez        <= 1'b0;
      r_canal      <= 1'b0;
      r_contador   <= '0;
      r_tx_partida <= 1'b0;
      r_tx_dados   <= '0;
      r_ack_a      <= 1'b0;
      r_ack_b      <= 1'b0;
      r_erro       <= 1'b0;
      r_ocupado    <= 1'b0;
    end else begin
      r_tx_partida <= 1'b0;
      r_ack_a      <= 1'b0;
      r_ack_b      <= 1'b0;
      r_erro       <= 1'b0;
      case (r_estado)
        INICIAL: begin
          r_estado  <= OCIOSO;
          r_ocupado <= 1'b0;
        end
        OCIOSO: begin
          if (req_a || req_b) begin
            r_canal   <= (req_a && req_b) ? r_vez : req_b;
            r_estado  <= CAPTURA;
            r_ocupado <= 1'b1;
          end else begin
            r_ocupado <= 1'b0;
          end
        end
        CAPTURA: begin
          r_tx_dados   <= r_canal ? dado_b : dado_a;
          r_tx_partida <= 1'b1;
          r_estado     <= PARTIDA;
        end
        PARTIDA: begin
          r_contador <= '0;
          r_estado   <= ESPERA;
        end
        ESPERA: begin
          if (w_fim_ok || w_fim_timeout) begin
            r_ack_a  <= !r_canal;
            r_ack_b  <= r_canal;
            r_erro   <= w_fim_timeout;
            r_estado <= FIM;
          end else if (r_contador != '1) begin
            r_contador <= r_contador + 1'b1;
          end
        end
        FIM: begin
          r_vez     <= !r_canal;
          r_estado  <= OCIOSO;
          r_ocupado <= 1'b0;
        end
        default: begin
          r_estado  <= INICIAL;
          r_ocupado <= 1'b0;
        end
      endcase
    end
  end

  assign tx_partida = r_tx_partida;
  assign tx_dados   = r_tx_dados;
  assign ack_a      = r_ack_a;
  assign ack_b      = r_ack_b;
  assign erro       = r_erro;
  assign ocupado    = r_ocupado;
  assign db_estado  = r_estado;
  assign db_vez     = r_vez;

endmodule

// File: tb/tb_arbitro_tx_serial.sv
// Testbench for arbitro_tx_serial: directed scenarios plus randomized
// transfers checked against a transaction-level model of the arbiter.
module tb_arbitro_tx_serial;

  localparam int unsigned TMO = 100;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0;
  logic [6:0] dado_a = '0;
  logic       req_b = 1'b0;
  logic [6:0] dado_b = '0;
  logic       tx_pronto = 1'b0;
  logic       tx_partida;
  logic [6:0] tx_dados;
  logic       ack_a;
  logic       ack_b;
  logic       erro;
  logic       ocupado;
  logic [3:0] db_estado;
  logic       db_vez;

  int checks = 0;
  int errors = 0;

  // Model state: pending requests, their data, and current priority.
  logic       m_pa = 1'b0;
  logic       m_pb = 1'b0;
  logic [6:0] m_da = '0;
  logic [6:0] m_db = '0;
  logic       m_vez = 1'b0;

  arbitro_tx_serial #(.TIMEOUT_CICLOS(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_a      (req_a),
    .dado_a     (dado_a),
    .req_b      (req_b),
    .dado_b     (dado_b),
    .tx_pronto  (tx_pronto),
    .tx_partida (tx_partida),
    .tx_dados   (tx_dados),
    .ack_a      (ack_a),
    .ack_b      (ack_b),
    .erro       (erro),
    .ocupado    (ocupado),
    .db_estado  (db_estado),
    .db_vez     (db_vez)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transfer. Called at a negedge with the DUT idle (OCIOSO).
  // d = ESPERA cycle (0-based) in which tx_pronto pulses; d >= TMO never pulses.
  task automatic run_one(input logic new_a, input logic [6:0] da,
                         input logic new_b, input logic [6:0] db,
                         input int d, input bit glitch, input bit scramble);
    logic       gnt;
    logic [6:0] exp_d;
    int         ack_idx;
    int         exp_idx;
    logic       exp_erro;
    logic       seen_a;
    logic       seen_b;
    logic       seen_e;
    bit         other_pend;
    if (new_a) begin req_a = 1'b1; dado_a = da; m_pa = 1'b1; m_da = da; end
    if (new_b) begin req_b = 1'b1; dado_b = db; m_pb = 1'b1; m_db = db; end
    gnt      = (m_pa && m_pb) ? m_vez : m_pb;
    exp_d    = gnt ? m_db : m_da;
    exp_idx  = ((d < int'(TMO) - 1) ? d : int'(TMO) - 1) + 1;
    exp_erro = (d >= int'(TMO));
    other_pend = gnt ? m_pa : m_pb;
    chk("idle_state", db_estado, 32'd1);
    chk("idle_vez", db_vez, m_vez);
    @(negedge clock);
    chk("partida_early", tx_partida, 32'd0);
    chk("busy_capture", ocupado, 32'd1);
    @(negedge clock);
    chk("partida_pulse", tx_partida, 32'd1);
    chk("tx_dados", tx_dados, exp_d);
    if (scramble) begin
      if (gnt) dado_b = dado_b ^ 7'h2A; else dado_a = dado_a ^ 7'h55;
    end
    @(negedge clock);
    chk("partida_once", tx_partida, 32'd0);
    ack_idx = -1;
    seen_a = 1'b0; seen_b = 1'b0; seen_e = 1'b0;
    for (int idx = 0; idx < 150; idx++) begin
      if (ack_a || ack_b) begin
        ack_idx = idx; seen_a = ack_a; seen_b = ack_b; seen_e = erro;
        break;
      end
      tx_pronto = (idx == d);
      if (glitch && !other_pend && exp_idx > 3) begin
        if (idx == 1) begin
          if (gnt) begin req_a = 1'b1; dado_a = 7'($urandom); end
          else     begin req_b = 1'b1; dado_b = 7'($urandom); end
        end else if (idx == 2) begin
          if (gnt) req_a = 1'b0; else req_b = 1'b0;
        end
      end
      @(negedge clock);
    end
    tx_pronto = 1'b0;
    chk("ack_cycle", ack_idx, exp_idx);
    chk("ack_a", seen_a, !gnt);
    chk("ack_b", seen_b, gnt);
    chk("erro", seen_e, exp_erro);
    chk("tx_dados_hold", tx_dados, exp_d);
    if (gnt) begin m_pb = 1'b0; req_b = 1'b0; end
    else     begin m_pa = 1'b0; req_a = 1'b0; end
    m_vez = !gnt;
    @(negedge clock);
    chk("ack_once", {ack_a, ack_b, erro}, 32'd0);
    chk("idle_free", ocupado, 32'd0);
    chk("vez_after", db_vez, m_vez);
  endtask

  function automatic int rand_delay();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 14) return int'($urandom_range(0, 20));
    if (r < 17) return int'(TMO) - 2 + int'($urandom_range(0, 2));
    return int'($urandom_range(TMO, TMO + 30));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic na;
    logic nb;
    repeat (3) @(negedge clock);
    chk("rst_partida", tx_partida, 32'd0);
    chk("rst_dados", tx_dados, 32'd0);
    chk("rst_acks", {ack_a, ack_b, erro}, 32'd0);
    chk("rst_ocupado", ocupado, 32'd0);
    chk("rst_estado", db_estado, 32'd0);
    chk("rst_vez", db_vez, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Simultaneous requests after reset, then fairness with B held high.
    run_one(1'b1, 7'h55, 1'b1, 7'h7E, 4, 1'b0, 1'b0);
    run_one(1'b1, 7'h41, 1'b0, 7'h00, 2, 1'b0, 1'b0);
    run_one(1'b0, 7'h00, 1'b1, 7'h42, 0, 1'b0, 1'b0);
    run_one(1'b1, 7'h43, 1'b0, 7'h00, 7, 1'b0, 1'b1);
    run_one(1'b0, 7'h00, 1'b0, 7'h00, 3, 1'b0, 1'b0);
    // Idle single request.
    run_one(1'b1, 7'h35, 1'b0, 7'h00, 5, 1'b0, 1'b0);
    // Timeout, then a normal transfer, then pronto coinciding with timeout.
    run_one(1'b0, 7'h00, 1'b1, 7'h61, 1000, 1'b0, 1'b0);
    run_one(1'b1, 7'h62, 1'b0, 7'h00, 1, 1'b1, 1'b0);
    run_one(1'b1, 7'h63, 1'b0, 7'h00, int'(TMO) - 1, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      na = !m_pa && ($urandom_range(0, 1) == 1);
      nb = !m_pb && ($urandom_range(0, 1) == 1);
      if (!m_pa && !m_pb && !na && !nb) na = 1'b1;
      run_one(na, 7'($urandom), nb, 7'($urandom), rand_delay(),
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
    end
    while (m_pa || m_pb) run_one(1'b0, 7'h00, 1'b0, 7'h00, 1, 1'b0, 1'b0);

    // Reset in the middle of ESPERA.
    req_b = 1'b1; dado_b = 7'h7F; m_pb = 1'b1; m_db = 7'h7F;
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_partida", tx_partida, 32'd0);
    chk("mid_rst_dados", tx_dados, 32'd0);
    chk("mid_rst_acks", {ack_a, ack_b, erro}, 32'd0);
    chk("mid_rst_ocupado", ocupado, 32'd0);
    chk("mid_rst_estado", db_estado, 32'd0);
    chk("mid_rst_vez", db_vez, 32'd0);
    m_vez = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("mid_rst_no_ack", ack_b, 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    run_one(1'b0, 7'h00, 1'b0, 7'h00, 6, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_tx_serial.md
ARBITRO_TX_SERIAL -- requirements
Module: arbitro_tx_serial

Interface
REQ-001 Parameter TIMEOUT_CICLOS, default 60000, is the maximum number of cycles spent waiting for tx_pronto before the character is aborted.
REQ-002 clock  in  1  system clock, 50 MHz, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; forces the reset state immediately, independent of clock.
REQ-004 req_a  in  1  channel A request (level), held until ack_a.
REQ-005 dado_a  in  7  channel A ASCII character, stable while req_a=1.
REQ-006 req_b  in  1  channel B request (level), held until ack_b.
REQ-007 dado_b  in  7  channel B ASCII character, stable while req_b=1.
REQ-008 tx_pronto  in  1  end-of-character indication from the 7N2 serial transmitter.
REQ-009 tx_partida  out  1  start pulse to the transmitter.
REQ-010 tx_dados  out  7  registered character to the transmitter.
REQ-011 ack_a / ack_b  out  1 each  one-cycle completion pulse per channel.
REQ-012 erro  out  1  one-cycle pulse coincident with ack_x when the character was aborted by timeout.
REQ-013 ocupado  out  1  high in every state except OCIOSO and INICIAL.
REQ-014 db_estado  out  4  current state code; db_vez  out  1  current priority (0=A, 1=B).

Function
REQ-015 The FSM SHALL have states INICIAL=0, OCIOSO=1, CAPTURA=2, PARTIDA=3, ESPERA=4, FIM=5, and encode all other codes as ERRO=F, which returns to INICIAL on the next cycle.
REQ-016 INICIAL SHALL go to OCIOSO unconditionally on the next cycle.
REQ-017 In OCIOSO with no request pending, the FSM SHALL remain in OCIOSO.
REQ-018 In OCIOSO with exactly one req, that channel SHALL be granted and the FSM SHALL go to CAPTURA.
REQ-019 In OCIOSO with both req, the channel indicated by vez SHALL be granted.
REQ-020 In CAPTURA, the granted dado_x SHALL be latched into tx_dados and the granted channel into an internal register canal; the FSM SHALL go to PARTIDA.
REQ-021 In PARTIDA, tx_partida SHALL be 1 for exactly this one cycle, the timeout counter SHALL clear to 0, and the FSM SHALL go to ESPERA.
REQ-022 Latency: tx_partida SHALL be high 2 cycles after the OCIOSO cycle in which req was sampled.
REQ-023 In ESPERA, the counter SHALL increment each cycle; tx_pronto=1 SHALL go to FIM with erro=0.
REQ-024 In ESPERA, if the counter reaches TIMEOUT_CICLOS-1 with tx_pronto=0, the FSM SHALL go to FIM with an internal abort flag set.
REQ-025 If tx_pronto=1 and the timeout occur in the same cycle, tx_pronto SHALL win (erro=0).
REQ-026 The counter SHALL be $clog2(TIMEOUT_CICLOS) bits wide, saturating, never wrapping.
REQ-027 In FIM, ack_<canal> SHALL be 1 for one cycle, erro SHALL equal the abort flag, vez SHALL become the channel not just served, and the FSM SHALL go to OCIOSO.
REQ-028 A req_x still high in the OCIOSO cycle after its ack SHALL be treated as a new request.
REQ-029 Changes on req_x or dado_x outside OCIOSO/CAPTURA SHALL have no effect on the transfer in progress.
REQ-030 tx_dados SHALL hold its value until the next CAPTURA.
REQ-031 A request deasserted before being granted SHALL be dropped silently, with no ack.

Reset
REQ-032 While reset=1: state=INICIAL, tx_partida=0, tx_dados=0000000, ack_a=ack_b=0, erro=0, ocupado=0, db_estado=0, vez=A, counter=0, abort flag=0.
REQ-033 Reset asserted mid-transfer SHALL abandon the transfer with no ack, and SHALL require a fresh req after release.

Verification
REQ-034 Idle single request: req_a=1 with dado_a=35h -> tx_dados=35h; tx_partida 1 cycle at +2; tx_pronto pulse -> ack_a pulse next cycle, erro=0; db_vez=1.
REQ-035 Simultaneous requests after reset: req_a (55h) and req_b (7Eh) together -> A served first, then B; exactly one ack each, in that order; db_vez=0 at end.
REQ-036 Fairness: req_b held high, req_a re-raised after each ack_a, 4 characters -> grants alternate A, B, A, B.
REQ-037 Timeout with TIMEOUT_CICLOS=100 and tx_pronto stuck at 0 -> ack_x and erro high together on the 100th cycle after entering ESPERA; the next request is still served normally.
REQ-038 Reset during ESPERA with req_b and 7Fh -> outputs at reset values immediately, no ack_b; after release with req_b still high -> fresh transfer of 7Fh.
REQ-039 tx_pronto=1 in the same cycle as the timeout -> ack with erro=0.
